// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master (sclk idles low, both ends sample on the sclk
// rising edge, MSB first) with an active-high chip select.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   start    transfer request, only looked at in IDLE
//   tx_data  word to send, captured when start is accepted
//   busy     high from acceptance until the transfer ends
//   done     one-cycle pulse when a transfer ends
//   rx_data  word captured from miso, held until the next done
//   sclk     serial clock, idle low
//   cs       chip select, active-high, idle low
//   mosi     serial data out, idle low
//   miso     serial data in, sampled raw on the clk edge where sclk rises
//
// state | meaning
// IDLE  | waiting for start, all serial outputs low
// LEAD  | cs high, sclk low for H cycles before the first rising edge
// HIGH  | sclk high for H cycles, miso was just sampled
// LOW   | sclk low for H cycles, mosi carries the next bit
// TRAIL | cs held high, sclk low for H cycles before cs drops
module spi_master #(
  parameter int DATA_W  = 4,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W:0]   rx_ext;
  logic              phase_end;

  // Shifts are written through wide intermediates so DATA_W=1 needs no
  // special-case slicing.
  assign tx_next   = tx_sr << 1;
  assign rx_ext    = {rx_sr, miso};
  assign phase_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      cs      <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sr   <= tx_data;
            rx_sr   <= '0;
            cs      <= 1'b1;
            busy    <= 1'b1;
            mosi    <= tx_data[DATA_W-1];
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= LEAD;
          end
        end
        LEAD, LOW: begin
          if (phase_end) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            rx_sr   <= rx_ext[DATA_W-1:0];
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HIGH: begin
          if (phase_end) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              // last bit stays on mosi through TRAIL
              state <= TRAIL;
            end else begin
              tx_sr <= tx_next;
              mosi  <= tx_next[DATA_W-1];
              state <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        TRAIL: begin
          if (phase_end) begin
            div_cnt <= '0;
            cs      <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sr;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed tests for spi_master. Instance 0 uses the defaults
// (DATA_W=4, CLK_DIV=2) with a bench-modelled slave echo (miso = mosi & cs)
// and LED shift chain; instance 1 uses DATA_W=8, CLK_DIV=1 with echo.
// A transfer-level model predicts every output each cycle from the offset
// since acceptance; literal checks pin the model to hand-computed values.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0;
  logic [3:0] tx0 = '0;
  logic       busy0, done0, sclk0, cs0, mosi0, miso0;
  logic [3:0] rx0;
  logic       stuck0 = 1'b0;

  logic       start1 = 1'b0;
  logic [7:0] tx1 = '0;
  logic       busy1, done1, sclk1, cs1, mosi1, miso1;
  logic [7:0] rx1;

  assign miso0 = stuck0 ? 1'b1 : (mosi0 & cs0);
  assign miso1 = mosi1 & cs1;

  spi_master #(.DATA_W(4), .CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .tx_data(tx0), .busy(busy0),
    .done(done0), .rx_data(rx0), .sclk(sclk0), .cs(cs0), .mosi(mosi0),
    .miso(miso0)
  );

  spi_master #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .busy(busy1),
    .done(done1), .rx_data(rx1), .sclk(sclk1), .cs(cs1), .mosi(mosi1),
    .miso(miso1)
  );

  // slave LED shift chain
  logic [3:0] led = '0;
  always @(posedge sclk0) if (cs0) led = {led[2:0], mosi0};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transfer-level model ----------------
  typedef struct {
    bit         act;
    bit         dn;
    int         off;
    logic [7:0] tx;
    logic [7:0] acc;
    logic [7:0] rx;
  } mstate_t;

  function automatic mstate_t mreset();
    mstate_t s;
    s.act = 0; s.dn = 0; s.off = 0; s.tx = '0; s.acc = '0; s.rx = '0;
    return s;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int dw, int h, bit st,
                                    logic [7:0] txd, bit mi);
    mstate_t n = s;
    int t = h * (2 * dw + 1);
    n.dn = 0;
    if (!s.act) begin
      if (st) begin
        n.act = 1; n.off = 0; n.tx = txd; n.acc = '0;
      end
    end else begin
      n.off = s.off + 1;
      if (n.off < 2 * dw * h && (n.off % (2 * h)) == h)
        n.acc = {n.acc[6:0], mi};
      if (n.off == t) begin
        n.act = 0;
        n.dn  = 1;
        n.rx  = n.acc & 8'((1 << dw) - 1);
      end
    end
    return n;
  endfunction

  // {cs, busy, sclk, mosi, done}
  function automatic logic [4:0] exp_vec(mstate_t s, int dw, int h);
    int p;
    logic sk, mo;
    if (!s.act) return {4'b0000, s.dn};
    p  = s.off / h;
    sk = (p % 2 == 1) && (p < 2 * dw);
    mo = (p < 2 * dw) ? s.tx[dw - 1 - p / 2] : s.tx[0];
    return {1'b1, 1'b1, sk, mo, 1'b0};
  endfunction

  mstate_t m0 = mreset();
  mstate_t m1 = mreset();
  bit st_s0, mi_s0, st_s1, mi_s1;
  logic [3:0] tx_s0;
  logic [7:0] tx_s1;

  always @(negedge clk) begin
    st_s0 = start0; mi_s0 = miso0; tx_s0 = tx0;
    st_s1 = start1; mi_s1 = miso1; tx_s1 = tx1;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m0 = mreset();
      m1 = mreset();
    end else begin
      m0 = mstep(m0, 4, 2, st_s0, {4'b0, tx_s0}, mi_s0);
      m1 = mstep(m1, 8, 1, st_s1, tx_s1, mi_s1);
    end
  end

  // ---------------- compare process + trackers ----------------
  int sclk_cnt0 = 0, done_cnt0 = 0, done_cyc0 = 0, busy_cnt0 = 0;
  int cs_rise0 = 0, cs_fall_cyc0 = 0, cs_low_len0 = 0;
  bit mosi_seen0 = 0;
  int sclk_cnt1 = 0, done_cnt1 = 0, done_cyc1 = 0, rise1_a = 0, rise1_b = 0;
  logic p_sclk0 = 0, p_cs0 = 0, p_sclk1 = 0;

  always @(posedge clk) begin
    #2;
    chk("vec0", {11'b0, cs0, busy0, sclk0, mosi0, done0}, {11'b0, exp_vec(m0, 4, 2)});
    chk("rx0", {12'b0, rx0}, {12'b0, m0.rx[3:0]});
    chk("vec1", {11'b0, cs1, busy1, sclk1, mosi1, done1}, {11'b0, exp_vec(m1, 8, 1)});
    chk("rx1", {8'b0, rx1}, {8'b0, m1.rx});
    if (sclk0 && !p_sclk0) sclk_cnt0++;
    if (done0) begin done_cnt0++; done_cyc0 = cyc; end
    if (busy0) busy_cnt0++;
    if (mosi0) mosi_seen0 = 1;
    if (!cs0 && p_cs0) cs_fall_cyc0 = cyc;
    if (cs0 && !p_cs0) begin
      cs_rise0++;
      if (cs_fall_cyc0 != 0) cs_low_len0 = cyc - cs_fall_cyc0;
    end
    if (sclk1 && !p_sclk1) begin
      sclk_cnt1++;
      if (sclk_cnt1 == 1) rise1_a = cyc;
      if (sclk_cnt1 == 2) rise1_b = cyc;
    end
    if (done1) begin done_cnt1++; done_cyc1 = cyc; end
    p_sclk0 = sclk0; p_cs0 = cs0; p_sclk1 = sclk1;
  end

  task automatic clr_trk();
    sclk_cnt0 = 0; done_cnt0 = 0; busy_cnt0 = 0; cs_rise0 = 0;
    cs_fall_cyc0 = 0; cs_low_len0 = 0; mosi_seen0 = 0;
    sclk_cnt1 = 0; done_cnt1 = 0; rise1_a = 0; rise1_b = 0;
  endtask

  // start pulse for one cycle; returns the accepting edge's cycle number
  task automatic go0(input logic [3:0] d, output int s);
    @(posedge clk); #1;
    start0 = 1'b1; tx0 = d; s = cyc + 1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int budget);
    int target;
    bit ok = 0;
    target = (inst == 0 ? done_cnt0 : done_cnt1) + 1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #3;
      if ((inst == 0 ? done_cnt0 : done_cnt1) >= target) begin ok = 1; break; end
    end
    chk(inst == 0 ? "done0_timeout" : "done1_timeout", {15'b0, ok}, 16'd1);
  endtask

  int s0, s1, d_first;

  initial begin
    #12;
    chk("reset_outs0", {10'b0, cs0, busy0, sclk0, mosi0, done0, 1'b0}, 16'd0);
    chk("reset_rx0", {12'b0, rx0}, 16'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // echo
    clr_trk(); led = '0;
    go0(4'b1011, s0);
    wait_done(0, 40);
    chk("echo_rx", {12'b0, rx0}, 16'b1011);
    chk("echo_led", {12'b0, led}, 16'b1011);
    chk("echo_done_edge", 16'(done_cyc0 - s0 + 1), 16'd19);
    chk("echo_sclk_pulses", 16'(sclk_cnt0), 16'd4);
    chk("echo_busy_cycles", 16'(busy_cnt0), 16'd18);

    // stuck-high miso
    repeat (3) @(posedge clk);
    clr_trk(); stuck0 = 1'b1;
    go0(4'b0000, s0);
    wait_done(0, 40);
    chk("stuck_rx", {12'b0, rx0}, 16'b1111);
    chk("stuck_mosi_seen", {15'b0, mosi_seen0}, 16'd0);
    @(posedge clk); #1; stuck0 = 1'b0;

    // start while busy
    repeat (3) @(posedge clk);
    clr_trk();
    go0(4'b1100, s0);
    while (cyc < s0 + 3) @(posedge clk);
    #1; start0 = 1'b1; tx0 = 4'b0101;
    @(posedge clk); #1; start0 = 1'b0;
    wait_done(0, 40);
    repeat (30) @(posedge clk);
    #3;
    chk("busy_start_rx", {12'b0, rx0}, 16'b1100);
    chk("busy_start_sclk", 16'(sclk_cnt0), 16'd4);
    chk("busy_start_dones", 16'(done_cnt0), 16'd1);
    chk("busy_start_cs_rises", 16'(cs_rise0), 16'd1);

    // back-to-back
    clr_trk();
    @(posedge clk); #1;
    start0 = 1'b1; tx0 = 4'b1001; s0 = cyc + 1;
    @(posedge clk); #1;
    tx0 = 4'b0110;
    wait_done(0, 40);
    d_first = done_cyc0;
    chk("b2b_rx_first", {12'b0, rx0}, 16'b1001);
    @(posedge clk); #1; start0 = 1'b0;
    wait_done(0, 40);
    chk("b2b_rx_second", {12'b0, rx0}, 16'b0110);
    chk("b2b_done_spacing", 16'(done_cyc0 - d_first), 16'd19);
    chk("b2b_sclk", 16'(sclk_cnt0), 16'd8);
    chk("b2b_cs_low", 16'(cs_low_len0), 16'd1);

    // reset mid-transfer
    repeat (3) @(posedge clk);
    clr_trk();
    go0(4'b1011, s0);
    while (cyc < s0 + 8) @(posedge clk);
    #1;
    chk("pre_rst_active", {14'b0, cs0, busy0}, 16'b11);
    #3; rst = 1'b1;
    #1;
    chk("async_rst_outs", {11'b0, sclk0, cs0, mosi0, busy0, done0}, 16'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    chk("rst_no_done", 16'(done_cnt0), 16'd0);
    clr_trk(); led = '0;
    go0(4'b1011, s0);
    wait_done(0, 40);
    chk("post_rst_rx", {12'b0, rx0}, 16'b1011);
    chk("post_rst_led", {12'b0, led}, 16'b1011);
    chk("post_rst_done_edge", 16'(done_cyc0 - s0 + 1), 16'd19);

    // parameter sweep instance
    repeat (3) @(posedge clk);
    clr_trk();
    @(posedge clk); #1;
    start1 = 1'b1; tx1 = 8'hA5; s1 = cyc + 1;
    @(posedge clk); #1; start1 = 1'b0;
    wait_done(1, 40);
    chk("sweep_rx", {8'b0, rx1}, 16'h00A5);
    chk("sweep_done_edge", 16'(done_cyc1 - s1 + 1), 16'd18);
    chk("sweep_sclk_period", 16'(rise1_b - rise1_a), 16'd2);
    chk("sweep_sclk_pulses", 16'(sclk_cnt1), 16'd8);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
